// File: rtl/led_pattern_pkg.sv
// Shared mode codes, FSM state encoding and small helpers for the LED pattern generator.
package led_pattern_pkg;

    localparam logic [1:0] MODE_FILL_CLEAR = 2'b00;
    localparam logic [1:0] MODE_FILL_DRAIN = 2'b01;
    localparam logic [1:0] MODE_RUN        = 2'b10;
    localparam logic [1:0] MODE_PINGPONG   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_PONG  = 3'd5
    } state_e;

    // Both FILL modes begin their period in FILL; RUN and PINGPONG have their own states.
    function automatic state_e firstState(input logic [1:0] mode);
        case (mode)
            MODE_RUN:      return ST_RUN;
            MODE_PINGPONG: return ST_PONG;
            default:       return ST_FILL;
        endcase
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step prescaler: TICK is high on the enabled cycle that ends each TICK_DIV-cycle window.
module led_tick_div #(
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign TICK = EN && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (EN) begin
            count_d = TICK ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: fill/clear, fill/drain, running light and ping-pong patterns.
// Define LED_PATTERN_INVERT_EN to drive Q active-low (bitwise complement of the pattern).
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1,
    parameter int HOLD     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    output logic [WIDTH-1:0] Q,
    output logic             DONE
);

    localparam int CNT_MAX = maxOf(maxOf(2 * WIDTH - 2, WIDTH), HOLD);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick;
    logic             fillDone;
    logic             periodEnd;
    logic [CW-1:0]    periodCnt;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] reversed;

    led_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .TICK(tick)
    );

    // cnt is the lit-bit count in FILL/DRAIN, the hold count in HOLD, and the
    // one-hot position plus one in RUN/PONG; zero always means a dark frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        fillDone  = 1'b0;
        periodEnd = 1'b0;
        periodCnt = '0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    mode_d  = MODE;
                    dir_d   = DIR;
                    state_d = firstState(MODE);
                    cnt_d   = '0;
                end
                ST_FILL: begin
                    if (cnt_q != CW'(WIDTH)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (HOLD > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CW'(1);
                    end else begin
                        fillDone = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != CW'(HOLD)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        fillDone = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q != CW'(1)) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        periodEnd = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != CW'(WIDTH)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        periodEnd = 1'b1;
                        periodCnt = CW'(1);
                    end
                end
                ST_PONG: begin
                    if (cnt_q != CW'(2 * WIDTH - 2)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        periodEnd = 1'b1;
                        periodCnt = CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (fillDone) begin
                if (mode_q == MODE_FILL_DRAIN) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    periodEnd = 1'b1;
                end
            end
            // Period boundary: re-sample MODE/DIR and restart in the new mode's first state.
            if (periodEnd) begin
                done_d  = 1'b1;
                mode_d  = MODE;
                dir_d   = DIR;
                state_d = firstState(MODE);
                cnt_d   = periodCnt;
            end
        end
    end

    always_comb begin
        pattern  = '0;
        reversed = '0;
        idx      = cnt_d - CW'(1);
        if ((state_d == ST_PONG) && (cnt_d > CW'(WIDTH))) begin
            idx = CW'(2 * WIDTH - 1) - cnt_d;
        end
        for (int i = 0; i < WIDTH; i++) begin
            case (state_d)
                ST_FILL, ST_DRAIN: pattern[i] = (CW'(i) < cnt_d);
                ST_HOLD:           pattern[i] = 1'b1;
                ST_RUN, ST_PONG:   pattern[i] = (cnt_d != '0) && (CW'(i) == idx);
                default:           pattern[i] = 1'b0;
            endcase
        end
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = pattern[WIDTH-1-i];
        end
        q_d = dir_d ? reversed : pattern;
`ifdef LED_PATTERN_INVERT_EN
        q_d = ~q_d;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LED_PATTERN_INVERT_EN
            q_q     <= '1;
`else
            q_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign Q    = q_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: four instances exercised one after another.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0, en1, en2, en3;
    logic [1:0] mode0, mode1, mode2, mode3;
    logic       dir0, dir1, dir2, dir3;
    logic [7:0] q0, q1, q3;
    logic [3:0] q2;
    logic       done0, done1, done2, done3;

    int assertCount = 0;
    int failCount   = 0;
    int doneSeen;

    // Hand-computed frame tables (pattern polarity, before any inversion).
    logic [7:0] seqA [12] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                              8'hFF, 8'h00, 8'h01, 8'h03};
    logic [7:0] seqB [10] = '{8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01,
                              8'h02, 8'h04};
    logic [7:0] seqC [3]  = '{8'h00, 8'h01, 8'h02};
    logic [7:0] seqD [20] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                              8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07,
                              8'h03, 8'h01, 8'h00, 8'h01};
    logic [3:0] seqE [14] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8,
                              4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [7:0] seqF [7]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(8), .TICK_DIV(1), .HOLD(0)) u0 (
        .CLK(clk), .RST(rst), .EN(en0), .MODE(mode0), .DIR(dir0), .Q(q0), .DONE(done0));
    led_pattern_gen #(.WIDTH(8), .TICK_DIV(1), .HOLD(2)) u1 (
        .CLK(clk), .RST(rst), .EN(en1), .MODE(mode1), .DIR(dir1), .Q(q1), .DONE(done1));
    led_pattern_gen #(.WIDTH(4), .TICK_DIV(1), .HOLD(0)) u2 (
        .CLK(clk), .RST(rst), .EN(en2), .MODE(mode2), .DIR(dir2), .Q(q2), .DONE(done2));
    led_pattern_gen #(.WIDTH(8), .TICK_DIV(3), .HOLD(0)) u3 (
        .CLK(clk), .RST(rst), .EN(en3), .MODE(mode3), .DIR(dir3), .Q(q3), .DONE(done3));

    function automatic logic [31:0] ledExp(input logic [31:0] v, input int w);
`ifdef LED_PATTERN_INVERT_EN
        return v ^ ((32'd1 << w) - 32'd1);
`else
        return v + 32'd0 * 32'(w);
`endif
    endfunction

    // Advance n cycles; inputs change and outputs are sampled on the falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        {en0, en1, en2, en3} = 4'b0000;
        {mode0, mode1, mode2, mode3} = 8'h00;
        {dir0, dir1, dir2, dir3} = 4'b0000;

        applyStimulus(15);
        checkOutput("reset q0", 32'(q0), ledExp(32'h00, 8));
        checkOutput("reset q1", 32'(q1), ledExp(32'h00, 8));
        checkOutput("reset q2", 32'(q2), ledExp(32'h0, 4));
        checkOutput("reset q3", 32'(q3), ledExp(32'h00, 8));
        checkOutput("reset done", 32'({done0, done1, done2, done3}), 32'h0);

        // FILL_CLEAR, then a mid-fill switch to RUN that waits for the period end.
        rst   = 1'b0;
        en0   = 1'b1;
        mode0 = 2'b00;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            checkOutput("fill_clear q", 32'(q0), ledExp(32'(seqA[i]), 8));
            checkOutput("fill_clear done", 32'(done0), 32'(i == 9));
        end
        mode0 = 2'b10;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("mode_switch q", 32'(q0), ledExp(32'(seqB[i]), 8));
            checkOutput("mode_switch done", 32'(done0), 32'(i == 6));
        end

        // Asynchronous reset in the middle of RUN.
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst q", 32'(q0), ledExp(32'h00, 8));
        checkOutput("async_rst done", 32'(done0), 32'h0);
        applyStimulus(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("post_rst q", 32'(q0), ledExp(32'(seqC[i]), 8));
        end
        en0 = 1'b0;

        // FILL_DRAIN with HOLD=2: 18-step period.
        en1   = 1'b1;
        mode1 = 2'b01;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            checkOutput("fill_drain q", 32'(q1), ledExp(32'(seqD[i]), 8));
            checkOutput("fill_drain done", 32'(done1), 32'(i == 18));
        end
        doneSeen = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1);
            if (done1) doneSeen++;
        end
        checkOutput("fill_drain no early done", 32'(doneSeen), 32'd0);
        applyStimulus(1);
        checkOutput("fill_drain period q", 32'(q1), ledExp(32'h00, 8));
        checkOutput("fill_drain period done", 32'(done1), 32'd1);
        en1 = 1'b0;

        // PINGPONG mirrored on a 4-bit bar.
        en2   = 1'b1;
        mode2 = 2'b11;
        dir2  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1);
            checkOutput("pong q", 32'(q2), ledExp(32'(seqE[i]), 4));
            checkOutput("pong done", 32'(done2), 32'((i == 7) || (i == 13)));
        end
        en2 = 1'b0;

        // RUN with TICK_DIV=3 and a five-cycle enable gap.
        en3   = 1'b1;
        mode3 = 2'b10;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1);
            checkOutput("run_div q", 32'(q3), ledExp(32'(seqF[i]), 8));
            checkOutput("run_div done", 32'(done3), 32'h0);
        end
        en3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("run_frozen q", 32'(q3), ledExp(32'h01, 8));
            checkOutput("run_frozen done", 32'(done3), 32'h0);
        end
        en3 = 1'b1;
        for (int r = 1; r <= 23; r++) begin
            applyStimulus(1);
            checkOutput("run_resume q", 32'(q3), ledExp(32'(8'd1 << (((r + 1) / 3) % 8)), 8));
            checkOutput("run_resume done", 32'(done3), 32'(r == 23));
        end
        en3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
